obi_sram_arbiter: RTL and testbench
===================================

Name: obi_sram_arbiter

Overview:
- Round-robin arbiter that shares one zero-wait OBI SRAM subordinate between NumMgr OBI managers, e.g. core instruction fetch and data ports, or core and debug/DMA.
- Sits between the managers and the SRAM subordinate.
- Tracks granted-but-unanswered transactions in an in-order ID FIFO and routes each response back to the manager that issued it.
- The subordinate side tolerates gnt stalls and multi-cycle response latency up to MaxTrans outstanding transactions.

Parameters:
- NumMgr, 2, number of requesting managers (>=2).
- MaxTrans, 2, maximum outstanding transactions and ID FIFO depth (>=1). Value 2 gives full throughput on a 1-cycle-latency SRAM.
- AddrWidth, 32, address width.
- DataWidth, 32, data width.
- BeWidth, DataWidth/8, byte-enable width.
- IdWidth (local), max(1,$clog2(NumMgr)), width of a manager index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active high.
- mgr_req_i  in  NumMgr  per-manager request.
- mgr_addr_i  in  NumMgr*AddrWidth  per-manager address (manager k occupies slice k).
- mgr_we_i  in  NumMgr  per-manager write enable.
- mgr_be_i  in  NumMgr*BeWidth  per-manager byte enables.
- mgr_wdata_i  in  NumMgr*DataWidth  per-manager write data.
- mgr_gnt_o  out  NumMgr  per-manager grant.
- mgr_rvalid_o  out  NumMgr  per-manager response valid.
- mgr_rdata_o  out  NumMgr*DataWidth  read data, broadcast to every slice.
- mgr_err_o  out  NumMgr  response error, broadcast; qualified by mgr_rvalid_o.
- sbr_req_o  out  1  request to SRAM.
- sbr_addr_o  out  AddrWidth  address.
- sbr_we_o  out  1  write enable.
- sbr_be_o  out  BeWidth  byte enables.
- sbr_wdata_o  out  DataWidth  write data.
- sbr_gnt_i  in  1  SRAM grant.
- sbr_rvalid_i  in  1  SRAM response valid.
- sbr_rdata_i  in  DataWidth  SRAM read data.
- sbr_err_i  in  1  SRAM error.
- spurious_rsp_o  out  1  single-cycle pulse when a response arrives with no outstanding transaction.

Behaviour:
- Reset (rst_i high at a clock edge):
  - rr_ptr=0, lock_vld=0, lock_id=0.
  - FIFO count=0, FIFO read and write pointers 0.
- Reset output values (combinational consequence of that state, regardless of inputs):
  - mgr_gnt_o=0, mgr_rvalid_o=0, spurious_rsp_o=0.
  - sbr_req_o=0, plus any mgr_req_i combination then arbitrates normally.
- Reset mid-operation discards all outstanding IDs. Responses that arrive afterwards are flagged spurious and dropped.
- Arbitration (combinational):
  - stall = (count==MaxTrans). Grants are blocked when full even if a pop happens in the same cycle.
  - If lock_vld: winner = lock_id.
  - Otherwise winner = first requesting manager scanning rr_ptr, rr_ptr+1, … mod NumMgr.
  - sbr_req_o = |mgr_req_i & !stall (when lock_vld, mgr_req_i[lock_id] & !stall).
  - sbr_addr_o/we/be/wdata = winner's slice. These are don't-care when sbr_req_o=0 but must be muxed, never X-forced.
  - mgr_gnt_o[winner] = sbr_req_o & sbr_gnt_i. All other grant bits are 0.
- Lock:
  - If sbr_req_o & !sbr_gnt_i, set lock_vld=1 and lock_id=winner.
  - This keeps address and attributes stable while the subordinate stalls (OBI rule).
  - Clear the lock on the grant handshake.
  - A manager that drops req while locked is a protocol violation; behaviour is undefined.
- Handshake (sbr_req_o & sbr_gnt_i):
  - Push winner into the FIFO.
  - rr_ptr <= (winner+1) mod NumMgr.
- Response (sbr_rvalid_i):
  - If count>0: mgr_rvalid_o[head]=1 in the same cycle (combinational, zero added latency), then pop.
  - If count==0: spurious_rsp_o=1, no manager sees rvalid, no pop.
- Simultaneous push and pop: count unchanged; both pointers advance. Pointers wrap at MaxTrans.
- Latency:
  - Grant is combinational with the request.
  - Against a gnt=req, 1-cycle-rvalid SRAM, a manager's response appears 1 cycle after its grant.
  - Back-to-back grants every cycle are sustained when MaxTrans>=2.
  - With MaxTrans=1, throughput is one transaction per 2 cycles.
- Reads and writes are treated identically; writes also receive rvalid.

Test Plan:
1. Single manager: mgr_req_i=2'b01, addr 0x100, read; SRAM returns 0xDEADBEEF the next cycle -> mgr_gnt_o=01 in cycle 0, mgr_rvalid_o=01 with rdata 0xDEADBEEF in cycle 1, spurious_rsp_o=0.
2. Contention: both managers request continuously for 6 cycles, rr_ptr=0 after reset -> grants alternate M0,M1,M0,M1,M0,M1; rvalid ids follow one cycle later in the same order; no grant in cycle 0 goes to M1.
3. Subordinate stall: M0 requests, sbr_gnt_i=0 for 3 cycles while M1 raises req in cycle 1 -> sbr_addr_o holds M0's address for all 4 cycles; M0 is granted in cycle 3; M1 is granted in cycle 4.
4. FIFO full, MaxTrans=2, rvalid delayed 3 cycles: M0 requests 3 times -> the first 2 are granted, sbr_req_o=0 with count=2, and the 3rd grant occurs only the cycle after the first rvalid pops.
5. Spurious response: after reset with no request, pulse sbr_rvalid_i -> spurious_rsp_o=1 for one cycle, mgr_rvalid_o=00, count remains 0.
6. Reset mid-flight: grant M1 (count=1), assert rst_i for 1 cycle before rvalid -> count=0, rr_ptr=0; the following sbr_rvalid_i raises spurious_rsp_o, and mgr_rvalid_o stays 00.

Source files
------------

// File: rtl/obi_sram_arbiter_if.sv
// obi_sram_arbiter_if: bundle of the manager-side and subordinate-side OBI
// signals around obi_sram_arbiter.
//   mgr_*_i / mgr_*_o : NumMgr managers, packed slice k belongs to manager k
//   sbr_*_o / sbr_*_i : single zero-wait SRAM subordinate
// Modports:
//   slave  : the arbiter's view (it serves the managers, drives the SRAM)
//   master : the environment's view (managers plus SRAM model)
interface obi_sram_arbiter_if #(
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8
);
    // Manager side
    logic [NumMgr-1:0]           mgr_req_i;
    logic [NumMgr*AddrWidth-1:0] mgr_addr_i;
    logic [NumMgr-1:0]           mgr_we_i;
    logic [NumMgr*BeWidth-1:0]   mgr_be_i;
    logic [NumMgr*DataWidth-1:0] mgr_wdata_i;
    logic [NumMgr-1:0]           mgr_gnt_o;
    logic [NumMgr-1:0]           mgr_rvalid_o;
    logic [NumMgr*DataWidth-1:0] mgr_rdata_o;
    logic [NumMgr-1:0]           mgr_err_o;

    // Subordinate side
    logic                 sbr_req_o;
    logic [AddrWidth-1:0] sbr_addr_o;
    logic                 sbr_we_o;
    logic [BeWidth-1:0]   sbr_be_o;
    logic [DataWidth-1:0] sbr_wdata_o;
    logic                 sbr_gnt_i;
    logic                 sbr_rvalid_i;
    logic [DataWidth-1:0] sbr_rdata_i;
    logic                 sbr_err_i;

    modport slave (
        input  mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
        output mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
        output sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o,
        input  sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i
    );

    modport master (
        output mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
        input  mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
        input  sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o,
        output sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i
    );
endinterface

// File: rtl/obi_sram_arbiter.sv
// obi_sram_arbiter: round-robin arbiter sharing one OBI SRAM subordinate
// between NumMgr OBI managers. Granted transactions are recorded in an
// in-order ID FIFO (depth MaxTrans) so each response is routed back to the
// manager that issued it. Grant and response routing are combinational.
// Ports:
//   clk_i          : clock
//   rst_i          : synchronous reset, active high
//   bus            : obi_sram_arbiter_if.slave, manager and SRAM signals
//   spurious_rsp_o : pulse when a response arrives with nothing outstanding
module obi_sram_arbiter #(
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned MaxTrans  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    obi_sram_arbiter_if.slave       bus,
    output logic                    spurious_rsp_o
);
    localparam int unsigned IdWidth  = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

    logic [IdWidth-1:0]  rr_ptr_q, rr_ptr_d;
    logic                lock_vld_q, lock_vld_d;
    logic [IdWidth-1:0]  lock_id_q, lock_id_d;
    logic [IdWidth-1:0]  fifo_q [MaxTrans];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;

    logic [IdWidth-1:0]  winner;
    logic                found;
    int unsigned         scan_idx;
    logic                stall;
    logic                req_any;
    logic                sbr_req;
    logic                handshake;
    logic                pop;

    // Winner selection: locked manager, else first requester from rr_ptr
    always_comb begin
        winner   = rr_ptr_q;
        found    = 1'b0;
        scan_idx = 0;
        if (lock_vld_q) begin
            winner = lock_id_q;
        end else begin
            for (int unsigned i = 0; i < NumMgr; i++) begin
                scan_idx = (32'(rr_ptr_q) + i) % NumMgr;
                if (!found && bus.mgr_req_i[IdWidth'(scan_idx)]) begin
                    found  = 1'b1;
                    winner = IdWidth'(scan_idx);
                end
            end
        end
    end

    // Request / handshake qualification; a full FIFO blocks grants even if
    // a response pops in the same cycle, keeping the count path simple.
    always_comb begin
        stall     = (count_q == CntWidth'(MaxTrans));
        req_any   = lock_vld_q ? bus.mgr_req_i[winner] : (|bus.mgr_req_i);
        sbr_req   = req_any & ~stall & ~rst_i;
        handshake = sbr_req & bus.sbr_gnt_i;
        pop       = bus.sbr_rvalid_i & (count_q != '0) & ~rst_i;
    end

    // Subordinate-side request and payload mux
    always_comb begin
        bus.sbr_req_o   = sbr_req;
        bus.sbr_addr_o  = bus.mgr_addr_i[32'(winner) * AddrWidth +: AddrWidth];
        bus.sbr_we_o    = bus.mgr_we_i[winner];
        bus.sbr_be_o    = bus.mgr_be_i[32'(winner) * BeWidth +: BeWidth];
        bus.sbr_wdata_o = bus.mgr_wdata_i[32'(winner) * DataWidth +: DataWidth];
    end

    // Manager-side grant and response routing (response goes to FIFO head)
    always_comb begin
        bus.mgr_gnt_o    = handshake ? (NumMgr'(1) << winner) : '0;
        bus.mgr_rvalid_o = pop ? (NumMgr'(1) << fifo_q[rd_ptr_q]) : '0;
        bus.mgr_rdata_o  = {NumMgr{bus.sbr_rdata_i}};
        bus.mgr_err_o    = {NumMgr{bus.sbr_err_i}};
        spurious_rsp_o   = bus.sbr_rvalid_i & (count_q == '0) & ~rst_i;
    end

    // Next state: round-robin pointer, stall lock, FIFO pointers and count
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (handshake) begin
            rr_ptr_d   = (winner == IdWidth'(NumMgr - 1)) ? '0 : winner + IdWidth'(1);
            lock_vld_d = 1'b0;
            wr_ptr_d   = (wr_ptr_q == PtrWidth'(MaxTrans - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
        end else if (sbr_req) begin
            // Subordinate stalled: pin the winner so the payload stays stable
            lock_vld_d = 1'b1;
            lock_id_d  = winner;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(MaxTrans - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
        end

        if (handshake && !pop) begin
            count_d = count_q + CntWidth'(1);
        end else if (!handshake && pop) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    // State registers; FIFO storage needs no reset since count gates reads
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (handshake) begin
                fifo_q[wr_ptr_q] <= winner;
            end
        end
    end
endmodule

// File: tb/tb_obi_sram_arbiter.sv
// Self-checking bench for obi_sram_arbiter: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_obi_sram_arbiter;
    localparam int unsigned N  = 2;
    localparam int unsigned MT = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic spurious;

    always #5 clk = ~clk;

    obi_sram_arbiter_if #(.NumMgr(N), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)) bus ();

    obi_sram_arbiter #(
        .NumMgr(N), .MaxTrans(MT), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus),
        .spurious_rsp_o (spurious)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: round-robin start, held (stalled) request, and
    // the list of managers whose transactions are still awaiting a response
    int       m_rr;
    bit       m_lock;
    int       m_lock_id;
    int       m_q[$];
    logic [AW-1:0] m_addr [N];
    logic          m_we   [N];

    // Expected outputs for the cycle currently being driven
    bit            e_req;
    logic [N-1:0]  e_gnt;
    logic [N-1:0]  e_rvalid;
    bit            e_spur;
    int            e_win;
    logic [DW-1:0] e_rdata;

    task automatic set_mgr(input int k, input logic [AW-1:0] a, input logic we,
                           input logic [BW-1:0] be, input logic [DW-1:0] wd);
        m_addr[k] = a;
        m_we[k]   = we;
        bus.mgr_addr_i[k*AW +: AW]  = a;
        bus.mgr_we_i[k]             = we;
        bus.mgr_be_i[k*BW +: BW]    = be;
        bus.mgr_wdata_i[k*DW +: DW] = wd;
    endtask

    // Apply one cycle of inputs after the falling edge and derive expectations
    task automatic drive(input logic [N-1:0] rq, input bit sg, input bit sv,
                         input logic [DW-1:0] rd, input bit rs);
        bit full;
        @(negedge clk);
        rst              = rs;
        bus.mgr_req_i    = rq;
        bus.sbr_gnt_i    = sg;
        bus.sbr_rvalid_i = sv;
        bus.sbr_rdata_i  = rd;
        bus.sbr_err_i    = rd[0];
        #1;
        e_win = -1;
        if (m_lock) begin
            e_win = m_lock_id;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (e_win < 0 && rq[(m_rr + i) % N]) e_win = (m_rr + i) % N;
            end
        end
        full  = (m_q.size() >= MT);
        e_req = 1'b0;
        if (!rs && !full && e_win >= 0) e_req = rq[e_win];
        e_gnt = '0;
        if (e_req && sg) e_gnt[e_win] = 1'b1;
        e_rvalid = '0;
        e_spur   = 1'b0;
        e_rdata  = rd;
        if (!rs && sv) begin
            if (m_q.size() > 0) e_rvalid[m_q[0]] = 1'b1;
            else e_spur = 1'b1;
        end
    endtask

    // Rising edge: advance the model with the cycle's outcome
    task automatic clock();
        @(posedge clk);
        if (rst) begin
            m_rr = 0;
            m_lock = 1'b0;
            m_q.delete();
        end else begin
            if (e_rvalid != '0) void'(m_q.pop_front());
            if (e_req && bus.sbr_gnt_i) begin
                m_q.push_back(e_win);
                m_rr   = (e_win + 1) % N;
                m_lock = 1'b0;
            end else if (e_req) begin
                m_lock    = 1'b1;
                m_lock_id = e_win;
            end
        end
    endtask

    task automatic pulse_reset();
        drive('0, 1'b0, 1'b0, '0, 1'b1);
        clock();
    endtask

    task automatic test_reset();
        drive(2'b11, 1'b1, 1'b1, 32'h1, 1'b1);
        n_checks++; if (bus.sbr_req_o !== 1'b0) begin n_errors++; $display("FAIL reset_sbr_req got %b want 0", bus.sbr_req_o); end
        n_checks++; if (bus.mgr_gnt_o !== 2'b00) begin n_errors++; $display("FAIL reset_gnt got %b want 00", bus.mgr_gnt_o); end
        n_checks++; if (bus.mgr_rvalid_o !== 2'b00) begin n_errors++; $display("FAIL reset_rvalid got %b want 00", bus.mgr_rvalid_o); end
        n_checks++; if (spurious !== 1'b0) begin n_errors++; $display("FAIL reset_spurious got %b want 0", spurious); end
        clock();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        n_checks++; if (bus.sbr_req_o !== 1'b0) begin n_errors++; $display("FAIL idle_sbr_req got %b want 0", bus.sbr_req_o); end
        clock();
    endtask

    task automatic test_single();
        pulse_reset();
        set_mgr(0, 32'h100, 1'b0, 4'hF, '0);
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (bus.mgr_gnt_o !== 2'b01) begin n_errors++; $display("FAIL single_gnt got %b want 01", bus.mgr_gnt_o); end
        n_checks++; if (bus.sbr_addr_o !== 32'h100) begin n_errors++; $display("FAIL single_addr got %h want 100", bus.sbr_addr_o); end
        clock();
        drive(2'b00, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        n_checks++; if (bus.mgr_rvalid_o !== 2'b01) begin n_errors++; $display("FAIL single_rvalid got %b want 01", bus.mgr_rvalid_o); end
        n_checks++; if (bus.mgr_rdata_o !== {2{32'hDEADBEEF}}) begin n_errors++; $display("FAIL single_rdata got %h want deadbeef x2", bus.mgr_rdata_o); end
        n_checks++; if (bus.mgr_err_o !== 2'b11) begin n_errors++; $display("FAIL single_err got %b want 11", bus.mgr_err_o); end
        n_checks++; if (spurious !== 1'b0) begin n_errors++; $display("FAIL single_spurious got %b want 0", spurious); end
        clock();
    endtask

    task automatic test_contention();
        logic [N-1:0] want;
        pulse_reset();
        set_mgr(0, 32'h1000, 1'b0, 4'hF, '0);
        set_mgr(1, 32'h2000, 1'b1, 4'hF, 32'hCAFE);
        for (int c = 0; c < 6; c++) begin
            drive(2'b11, 1'b1, c > 0, DW'(c), 1'b0);
            want = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++; if (bus.mgr_gnt_o !== want) begin n_errors++; $display("FAIL contention_gnt c%0d got %b want %b", c, bus.mgr_gnt_o, want); end
            if (c > 0) begin
                want = (c % 2 == 1) ? 2'b01 : 2'b10;
                n_checks++; if (bus.mgr_rvalid_o !== want) begin n_errors++; $display("FAIL contention_rvalid c%0d got %b want %b", c, bus.mgr_rvalid_o, want); end
            end
            clock();
        end
        drive(2'b00, 1'b1, 1'b1, '0, 1'b0);
        n_checks++; if (bus.mgr_rvalid_o !== 2'b10) begin n_errors++; $display("FAIL contention_last_rvalid got %b want 10", bus.mgr_rvalid_o); end
        clock();
    endtask

    task automatic test_stall();
        pulse_reset();
        set_mgr(0, 32'hA000_0000, 1'b0, 4'hF, '0);
        set_mgr(1, 32'hB000_0004, 1'b1, 4'h3, 32'h1234);
        for (int c = 0; c < 4; c++) begin
            drive((c == 0) ? 2'b01 : 2'b11, c == 3, 1'b0, '0, 1'b0);
            n_checks++; if (bus.sbr_addr_o !== 32'hA000_0000) begin n_errors++; $display("FAIL stall_addr c%0d got %h want a0000000", c, bus.sbr_addr_o); end
            n_checks++; if (bus.mgr_gnt_o !== ((c == 3) ? 2'b01 : 2'b00)) begin n_errors++; $display("FAIL stall_gnt c%0d got %b", c, bus.mgr_gnt_o); end
            clock();
        end
        drive(2'b10, 1'b1, 1'b1, 32'h55, 1'b0);
        n_checks++; if (bus.mgr_gnt_o !== 2'b10) begin n_errors++; $display("FAIL stall_m1_gnt got %b want 10", bus.mgr_gnt_o); end
        n_checks++; if (bus.sbr_we_o !== 1'b1) begin n_errors++; $display("FAIL stall_m1_we got %b want 1", bus.sbr_we_o); end
        n_checks++; if (bus.mgr_rvalid_o !== 2'b01) begin n_errors++; $display("FAIL stall_m0_rvalid got %b want 01", bus.mgr_rvalid_o); end
        clock();
        drive(2'b00, 1'b1, 1'b1, '0, 1'b0);
        n_checks++; if (bus.mgr_rvalid_o !== 2'b10) begin n_errors++; $display("FAIL stall_m1_rvalid got %b want 10", bus.mgr_rvalid_o); end
        clock();
    endtask

    task automatic test_fifo_full();
        logic [N-1:0] gnt_w   [7] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        logic [N-1:0] rval_w  [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        bit           sreq_w  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bit           spur_w  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        pulse_reset();
        set_mgr(0, 32'h200, 1'b0, 4'hF, '0);
        for (int c = 0; c < 7; c++) begin
            drive((c < 5) ? 2'b01 : 2'b00, 1'b1, c >= 3, DW'(c), 1'b0);
            n_checks++; if (bus.sbr_req_o !== sreq_w[c]) begin n_errors++; $display("FAIL full_sbr_req c%0d got %b want %b", c, bus.sbr_req_o, sreq_w[c]); end
            n_checks++; if (bus.mgr_gnt_o !== gnt_w[c]) begin n_errors++; $display("FAIL full_gnt c%0d got %b want %b", c, bus.mgr_gnt_o, gnt_w[c]); end
            n_checks++; if (bus.mgr_rvalid_o !== rval_w[c]) begin n_errors++; $display("FAIL full_rvalid c%0d got %b want %b", c, bus.mgr_rvalid_o, rval_w[c]); end
            n_checks++; if (spurious !== spur_w[c]) begin n_errors++; $display("FAIL full_spurious c%0d got %b want %b", c, spurious, spur_w[c]); end
            clock();
        end
    endtask

    task automatic test_spurious();
        pulse_reset();
        drive(2'b00, 1'b1, 1'b1, 32'h9, 1'b0);
        n_checks++; if (spurious !== 1'b1) begin n_errors++; $display("FAIL spur_pulse got %b want 1", spurious); end
        n_checks++; if (bus.mgr_rvalid_o !== 2'b00) begin n_errors++; $display("FAIL spur_rvalid got %b want 00", bus.mgr_rvalid_o); end
        clock();
        drive(2'b10, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (spurious !== 1'b0) begin n_errors++; $display("FAIL spur_single_cycle got %b want 0", spurious); end
        n_checks++; if (bus.mgr_gnt_o !== 2'b10) begin n_errors++; $display("FAIL spur_next_gnt got %b want 10", bus.mgr_gnt_o); end
        clock();
        drive(2'b00, 1'b1, 1'b1, '0, 1'b0);
        n_checks++; if (bus.mgr_rvalid_o !== 2'b10) begin n_errors++; $display("FAIL spur_next_rvalid got %b want 10", bus.mgr_rvalid_o); end
        clock();
        drive(2'b00, 1'b1, 1'b1, '0, 1'b0);
        n_checks++; if (spurious !== 1'b1) begin n_errors++; $display("FAIL spur_empty_again got %b want 1", spurious); end
        clock();
    endtask

    task automatic test_reset_midflight();
        pulse_reset();
        drive(2'b10, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (bus.mgr_gnt_o !== 2'b10) begin n_errors++; $display("FAIL mid_gnt_m1 got %b want 10", bus.mgr_gnt_o); end
        clock();
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (bus.mgr_gnt_o !== 2'b01) begin n_errors++; $display("FAIL mid_gnt_m0 got %b want 01", bus.mgr_gnt_o); end
        clock();
        drive(2'b11, 1'b1, 1'b0, '0, 1'b1);
        n_checks++; if (bus.mgr_gnt_o !== 2'b00) begin n_errors++; $display("FAIL mid_reset_gnt got %b want 00", bus.mgr_gnt_o); end
        clock();
        drive(2'b11, 1'b1, 1'b1, 32'h77, 1'b0);
        n_checks++; if (spurious !== 1'b1) begin n_errors++; $display("FAIL mid_spurious got %b want 1", spurious); end
        n_checks++; if (bus.mgr_rvalid_o !== 2'b00) begin n_errors++; $display("FAIL mid_rvalid got %b want 00", bus.mgr_rvalid_o); end
        n_checks++; if (bus.mgr_gnt_o !== 2'b01) begin n_errors++; $display("FAIL mid_rr_restart got %b want 01", bus.mgr_gnt_o); end
        clock();
        drive(2'b00, 1'b1, 1'b1, '0, 1'b0);
        n_checks++; if (bus.mgr_rvalid_o !== 2'b01) begin n_errors++; $display("FAIL mid_after_rvalid got %b want 01", bus.mgr_rvalid_o); end
        clock();
    endtask

    task automatic test_random();
        logic [N-1:0] rq;
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!(m_lock && k == m_lock_id)) set_mgr(k, $urandom, 1'($urandom), 4'($urandom), $urandom);
            end
            rq = N'($urandom);
            if (m_lock) rq[m_lock_id] = 1'b1;
            drive(rq, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 49) == 0);
            n_checks++; if (bus.sbr_req_o !== e_req) begin n_errors++; $display("FAIL rand_sbr_req c%0d got %b want %b", c, bus.sbr_req_o, e_req); end
            n_checks++; if (bus.mgr_gnt_o !== e_gnt) begin n_errors++; $display("FAIL rand_gnt c%0d got %b want %b", c, bus.mgr_gnt_o, e_gnt); end
            n_checks++; if (bus.mgr_rvalid_o !== e_rvalid) begin n_errors++; $display("FAIL rand_rvalid c%0d got %b want %b", c, bus.mgr_rvalid_o, e_rvalid); end
            n_checks++; if (spurious !== e_spur) begin n_errors++; $display("FAIL rand_spurious c%0d got %b want %b", c, spurious, e_spur); end
            if (e_req) begin
                n_checks++; if (bus.sbr_addr_o !== m_addr[e_win]) begin n_errors++; $display("FAIL rand_addr c%0d got %h want %h", c, bus.sbr_addr_o, m_addr[e_win]); end
                n_checks++; if (bus.sbr_we_o !== m_we[e_win]) begin n_errors++; $display("FAIL rand_we c%0d got %b want %b", c, bus.sbr_we_o, m_we[e_win]); end
            end
            if (e_rvalid != '0) begin
                n_checks++; if (bus.mgr_rdata_o !== {N{e_rdata}}) begin n_errors++; $display("FAIL rand_rdata c%0d got %h want %h", c, bus.mgr_rdata_o, e_rdata); end
            end
            clock();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        m_rr = 0; m_lock = 1'b0; m_lock_id = 0;
        bus.mgr_req_i = '0; bus.mgr_addr_i = '0; bus.mgr_we_i = '0;
        bus.mgr_be_i = '0; bus.mgr_wdata_i = '0;
        bus.sbr_gnt_i = 1'b0; bus.sbr_rvalid_i = 1'b0;
        bus.sbr_rdata_i = '0; bus.sbr_err_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_addr[k] = '0;
            m_we[k]   = 1'b0;
        end
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_fifo_full();
        test_spurious();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
